mux_logic_unit: RTL and testbench
=================================

MUX_LOGIC_UNIT -- requirements
Module: mux_logic_unit

Interface
REQ-001 Parameter: WIDTH, 8, operand/result width in bits (legal range 1..32).
REQ-002 Parameter: CNT_W, 8, width of the accepted-operation counter.
REQ-003 Port: clk  in  1  single clock; all state updates on its rising edge.
REQ-004 Port: rst  in  1  reset, asynchronous and active-high.
REQ-005 Port: in_valid  in  1  operand beat valid.
REQ-006 Port: in_ready  out  1  block can accept an operand beat.
REQ-007 Port: a  in  WIDTH  operand A.
REQ-008 Port: b  in  WIDTH  operand B.
REQ-009 Port: op  in  3  operation select, sampled with the beat.
REQ-010 Port: acc_en  in  1  when 1, the accumulator replaces operand A for this beat.
REQ-011 Port: acc_clr  in  1  synchronous accumulator clear.
REQ-012 Port: out_valid  out  1  result beat valid.
REQ-013 Port: out_ready  in  1  downstream accepts the result beat.
REQ-014 Port: y  out  WIDTH  registered result.
REQ-015 Port: zero  out  1  registered flag, 1 when y == 0.
REQ-016 Port: op_count  out  CNT_W  number of accepted beats, saturating.

Function
REQ-017 Every result bit SHALL be produced by a 2:1 mux instance per bit, with select = A bit and data inputs taken from {0, 1, B, ~B}. No direct gate operators are used on the datapath.
REQ-018 Op encoding SHALL be:
- 000 NOT: ~B (select forced 1).
- 001 OR.
- 010 AND.
- 011 NAND.
- 100 NOR.
- 101 XOR.
- 110 XNOR.
- 111 PASS: A.
REQ-019 Effective A SHALL be acc when acc_en=1, else port a.
REQ-020 A beat SHALL be accepted when in_valid && in_ready.
REQ-021 A result SHALL be consumed when out_valid && out_ready.
REQ-022 in_ready SHALL equal !out_valid || out_ready, so the block is a single-register pipeline with pass-through backpressure.
REQ-023 Latency SHALL be 1 cycle: a beat accepted on edge N presents y/zero with out_valid=1 after edge N. Full throughput of 1 beat/cycle is sustained while out_ready=1.
REQ-024 On accept, y and zero SHALL load and out_valid SHALL become 1.
REQ-025 On consume without accept, out_valid SHALL become 0.
REQ-026 On simultaneous consume and accept, out_valid SHALL stay 1 and the new result SHALL load.
REQ-027 While out_valid=1 and out_ready=0, y, zero and out_valid SHALL hold stable, and inputs SHALL be ignored.
REQ-028 Accumulator acc (WIDTH bits, internal) SHALL update on accept with acc_en=1, taking the new result as its value.
REQ-029 Accepts with acc_en=0 SHALL leave acc unchanged.
REQ-030 acc_clr=1 SHALL set acc to 0 on that edge, independent of handshake. When acc_clr coincides with an acc_en accept, the result SHALL use the old acc, and the clear SHALL win for the acc update.
REQ-031 op_count SHALL increment by 1 per accepted beat and saturate at 2^CNT_W-1 without wrapping.
REQ-032 op and b SHALL have no effect on state when no accept occurs.

Reset
REQ-033 While rst=1, asynchronously, out_valid SHALL be 0, y SHALL be 0, zero SHALL be 1, acc SHALL be 0, and op_count SHALL be 0.
REQ-034 in_ready SHALL be 1 during and after reset.
REQ-035 Reset asserted mid-operation SHALL discard any held result. The first beat after rst falls SHALL be accepted normally.

Verification
REQ-036 Truth table: WIDTH=8, a=8'hF0, b=8'hCC, out_ready=1, sweep op 000..111. The expected y sequence is 33, FC, C0, 3F, 03, 3C, C3, F0, each 1 cycle after its beat. zero=0 for all.
REQ-037 Backpressure: out_ready=0, send 2 beats (op=001 a=01 b=02, then op=010). The first result y=03 SHALL hold, in_ready SHALL be 0, and the second beat SHALL not be accepted until out_ready=1. No loss and no duplication.
REQ-038 Accumulate: acc_clr pulse, then acc_en=1 op=001 b=01, 02, 04, 08. y SHALL be 01, 03, 07, 0F. Then op=101 b=0F SHALL give y=00 with zero=1.
REQ-039 Clear collision: acc=0F, then acc_clr=1 with an acc_en accept op=111. y SHALL be 0F and acc SHALL be 00 afterwards.
REQ-040 Saturation: CNT_W=2, 6 accepted beats. op_count SHALL read 1, 2, 3, 3, 3, 3.
REQ-041 Reset mid-stream: with out_valid=1 and out_ready=0, pulse rst between edges. The outputs SHALL go immediately to out_valid=0, y=0, zero=1, op_count=0, and in_ready=1.

Source files
------------

// File: rtl/mux_logic_unit.sv
// Bitwise logic unit built from one 2:1 mux per result bit, behind a single
// valid/ready register stage, with an accumulator feedback path and a saturating beat counter.

module mlu_mux2 (
    input  logic sel_i,
    input  logic d0_i,
    input  logic d1_i,
    output logic y_o
);
    assign y_o = sel_i ? d1_i : d0_i;
endmodule

module mux_logic_unit #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [2:0]       op,
    input  logic             acc_en,
    input  logic             acc_clr,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] y,
    output logic             zero,
    output logic [CNT_W-1:0] op_count
);

    typedef enum logic [2:0] {
        OP_NOT  = 3'b000,
        OP_OR   = 3'b001,
        OP_AND  = 3'b010,
        OP_NAND = 3'b011,
        OP_NOR  = 3'b100,
        OP_XOR  = 3'b101,
        OP_XNOR = 3'b110,
        OP_PASS = 3'b111
    } op_e;

    // Mux data-input sources; d0 is taken when the A bit is 0, d1 when it is 1.
    typedef enum logic [1:0] {
        SRC_ZERO = 2'b00,
        SRC_ONE  = 2'b01,
        SRC_B    = 2'b10,
        SRC_NB   = 2'b11
    } src_e;

    logic             out_valid_q, out_valid_d;
    logic [WIDTH-1:0] y_q, y_d;
    logic             zero_q, zero_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic             accept;
    logic             consume;
    logic [WIDTH-1:0] a_eff;
    logic [WIDTH-1:0] sel_vec;
    logic [WIDTH-1:0] d0_vec;
    logic [WIDTH-1:0] d1_vec;
    logic [WIDTH-1:0] result;
    logic             result_zero;
    logic             sel_force;
    src_e             src0;
    src_e             src1;

    function automatic logic [WIDTH-1:0] pick(input src_e s, input logic [WIDTH-1:0] bv);
        logic [WIDTH-1:0] r;
        case (s)
            SRC_ZERO: r = '0;
            SRC_ONE:  r = '1;
            SRC_B:    r = bv;
            SRC_NB:   r = ~bv;
            default:  r = '0;
        endcase
        return r;
    endfunction

    assign in_ready = !out_valid_q || out_ready;
    assign accept   = in_valid && in_ready;
    assign consume  = out_valid_q && out_ready;
    assign a_eff    = acc_en ? acc_q : a;

    // Op decode into per-bit mux source selection.
    always_comb begin
        sel_force = 1'b0;
        src0      = SRC_ZERO;
        src1      = SRC_ZERO;
        case (op_e'(op))
            OP_NOT:  begin sel_force = 1'b1; src0 = SRC_NB; src1 = SRC_NB; end
            OP_OR:   begin src0 = SRC_B;    src1 = SRC_ONE;  end
            OP_AND:  begin src0 = SRC_ZERO; src1 = SRC_B;    end
            OP_NAND: begin src0 = SRC_ONE;  src1 = SRC_NB;   end
            OP_NOR:  begin src0 = SRC_NB;   src1 = SRC_ZERO; end
            OP_XOR:  begin src0 = SRC_B;    src1 = SRC_NB;   end
            OP_XNOR: begin src0 = SRC_NB;   src1 = SRC_B;    end
            OP_PASS: begin src0 = SRC_ZERO; src1 = SRC_ONE;  end
            default: begin src0 = SRC_ZERO; src1 = SRC_ZERO; end
        endcase
    end

    assign d0_vec      = pick(src0, b);
    assign d1_vec      = pick(src1, b);
    assign sel_vec     = sel_force ? {WIDTH{1'b1}} : a_eff;
    assign result_zero = (result == '0);

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        mlu_mux2 u_mux (
            .sel_i (sel_vec[i]),
            .d0_i  (d0_vec[i]),
            .d1_i  (d1_vec[i]),
            .y_o   (result[i])
        );
    end

    // Output register, accumulator and counter next-state.
    always_comb begin
        out_valid_d = out_valid_q;
        y_d         = y_q;
        zero_d      = zero_q;
        acc_d       = acc_q;
        cnt_d       = cnt_q;
        if (accept) begin
            out_valid_d = 1'b1;
            y_d         = result;
            zero_d      = result_zero;
            if (cnt_q != {CNT_W{1'b1}}) begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end else if (consume) begin
            out_valid_d = 1'b0;
        end
        // Clear wins over an accumulating accept on the same edge.
        if (acc_clr) begin
            acc_d = '0;
        end else if (accept && acc_en) begin
            acc_d = result;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            y_q         <= '0;
            zero_q      <= 1'b1;
            acc_q       <= '0;
            cnt_q       <= '0;
        end else begin
            out_valid_q <= out_valid_d;
            y_q         <= y_d;
            zero_q      <= zero_d;
            acc_q       <= acc_d;
            cnt_q       <= cnt_d;
        end
    end

    assign out_valid = out_valid_q;
    assign y         = y_q;
    assign zero      = zero_q;
    assign op_count  = cnt_q;

endmodule

// File: tb/tb_mux_logic_unit.sv
// Scoreboard bench for mux_logic_unit: a reference model predicts each result beat,
// a negedge monitor compares presented outputs; a second instance with CNT_W=2 checks saturation.

module tb_mux_logic_unit;

    localparam int unsigned W = 8;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         in_ready, in_ready_s;
    logic [W-1:0] a, b;
    logic [2:0]   op;
    logic         acc_en, acc_clr;
    logic         out_valid, out_valid_s;
    logic         out_ready;
    logic [W-1:0] y, y_s;
    logic         zero, zero_s;
    logic [7:0]   op_count;
    logic [1:0]   op_count_s;

    typedef struct packed {
        logic [W-1:0] y;
        logic         z;
    } exp_t;

    exp_t         exp_q[$];
    int           n_cmp  = 0;
    int           n_fail = 0;
    logic         m_ov   = 1'b0;
    logic [W-1:0] m_acc  = '0;
    int           m_cnt  = 0;
    bit           mon_en = 1'b0;

    always #5 clk = ~clk;

    mux_logic_unit #(.WIDTH(W), .CNT_W(8)) u_dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .op(op), .acc_en(acc_en), .acc_clr(acc_clr),
        .out_valid(out_valid), .out_ready(out_ready), .y(y), .zero(zero),
        .op_count(op_count)
    );

    mux_logic_unit #(.WIDTH(W), .CNT_W(2)) u_sat (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_s),
        .a(a), .b(b), .op(op), .acc_en(acc_en), .acc_clr(acc_clr),
        .out_valid(out_valid_s), .out_ready(out_ready), .y(y_s), .zero(zero_s),
        .op_count(op_count_s)
    );

    function automatic logic [W-1:0] ref_op(input logic [2:0] o, input logic [W-1:0] av, input logic [W-1:0] bv);
        case (o)
            3'd0: return ~bv;
            3'd1: return av | bv;
            3'd2: return av & bv;
            3'd3: return ~(av & bv);
            3'd4: return ~(av | bv);
            3'd5: return av ^ bv;
            3'd6: return ~(av ^ bv);
            default: return av;
        endcase
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // One cycle of stimulus, entered and left at posedge+1; the model advances with the edge.
    task automatic step(input bit iv, input logic [W-1:0] av, input logic [W-1:0] bv,
                        input logic [2:0] opv, input bit ae, input bit ac, input bit ordy);
        logic         rdy_exp, acc_ok, n_ov;
        logic [W-1:0] r, n_acc;
        int           n_cnt;
        exp_t         e;
        in_valid = iv; a = av; b = bv; op = opv; acc_en = ae; acc_clr = ac; out_ready = ordy;
        #1;
        rdy_exp = !m_ov || ordy;
        chk("in_ready", 32'(in_ready), 32'(rdy_exp));
        acc_ok = iv && rdy_exp;
        r      = ref_op(opv, ae ? m_acc : av, bv);
        n_ov   = acc_ok ? 1'b1 : ((m_ov && ordy) ? 1'b0 : m_ov);
        n_acc  = ac ? '0 : ((acc_ok && ae) ? r : m_acc);
        n_cnt  = acc_ok ? m_cnt + 1 : m_cnt;
        if (acc_ok) begin
            e.y = r;
            e.z = (r == '0);
            exp_q.push_back(e);
        end
        @(posedge clk);
        #1;
        m_ov  = n_ov;
        m_acc = n_acc;
        m_cnt = n_cnt;
    endtask

    // Stall a result, then pulse reset between clock edges.
    task automatic reset_mid();
        in_valid = 1'b0; out_ready = 1'b0;
        chk("pre_rst_out_valid", 32'(out_valid), 32'd1);
        #1 rst = 1'b1;
        #1;
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_y", 32'(y), 32'd0);
        chk("rst_zero", 32'(zero), 32'd1);
        chk("rst_op_count", 32'(op_count), 32'd0);
        chk("rst_op_count_sat", 32'(op_count_s), 32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        exp_q.delete();
        m_ov = 1'b0; m_acc = '0; m_cnt = 0;
        #1 rst = 1'b0;
        @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        if (mon_en && !rst) begin
            chk("out_valid", 32'(out_valid), 32'(m_ov));
            chk("op_count", 32'(op_count), 32'((m_cnt > 255) ? 255 : m_cnt));
            chk("op_count_sat", 32'(op_count_s), 32'((m_cnt > 3) ? 3 : m_cnt));
            if (out_valid) begin
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_fail++;
                    $display("FAIL unexpected_beat: got y=%0h expected no result at %0t", y, $time);
                end else begin
                    chk("y", 32'(y), 32'(exp_q[0].y));
                    chk("zero", 32'(zero), 32'(exp_q[0].z));
                    if (out_ready) void'(exp_q.pop_front());
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b0; in_valid = 1'b0; a = '0; b = '0; op = '0;
        acc_en = 1'b0; acc_clr = 1'b0; out_ready = 1'b1;
        #1 rst = 1'b1;
        #1;
        chk("init_out_valid", 32'(out_valid), 32'd0);
        chk("init_y", 32'(y), 32'd0);
        chk("init_zero", 32'(zero), 32'd1);
        chk("init_op_count", 32'(op_count), 32'd0);
        chk("init_in_ready", 32'(in_ready), 32'd1);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        mon_en = 1'b1;

        // Truth table sweep.
        for (int i = 0; i < 8; i++) step(1, 8'hF0, 8'hCC, 3'(i), 0, 0, 1);
        step(0, 0, 0, 0, 0, 0, 1);

        // Backpressure: second beat must wait for out_ready.
        step(1, 8'h01, 8'h02, 3'b001, 0, 0, 0);
        step(1, 8'h01, 8'h02, 3'b010, 0, 0, 0);
        step(1, 8'h01, 8'h02, 3'b010, 0, 0, 0);
        step(1, 8'h01, 8'h02, 3'b010, 0, 0, 1);
        step(0, 0, 0, 0, 0, 0, 1);

        // Accumulate chain, then XOR to zero.
        step(0, 0, 0, 0, 0, 1, 1);
        step(1, 8'h00, 8'h01, 3'b001, 1, 0, 1);
        step(1, 8'h00, 8'h02, 3'b001, 1, 0, 1);
        step(1, 8'h00, 8'h04, 3'b001, 1, 0, 1);
        step(1, 8'h00, 8'h08, 3'b001, 1, 0, 1);
        step(1, 8'h00, 8'h0F, 3'b101, 1, 0, 1);

        // Clear colliding with an accumulating PASS.
        step(1, 8'h00, 8'h0F, 3'b001, 1, 0, 1);
        step(1, 8'h00, 8'h00, 3'b111, 1, 1, 1);
        step(1, 8'hA5, 8'h00, 3'b111, 1, 0, 1);

        // Reset while a result is held.
        step(1, 8'h55, 8'hAA, 3'b001, 0, 0, 0);
        reset_mid();
        step(1, 8'h12, 8'h34, 3'b010, 0, 0, 1);

        for (int i = 0; i < 400; i++) begin
            step(($urandom % 4) != 0, 8'($urandom), 8'($urandom), 3'($urandom),
                 ($urandom % 3) == 0, ($urandom % 10) == 0, ($urandom % 3) != 0);
        end

        for (int i = 0; i < 3; i++) step(0, 0, 0, 0, 0, 0, 1);
        chk("drain_queue", 32'(exp_q.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
